// File: rtl/axi_write_master_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_write_master_if : requester + AXI3 AW/W/B signal bundle
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
interface axi_write_master_if #(
    parameter int BUSWIDTH = 32
);
    logic                req_valid;
    logic                req_ready;
    logic [31:0]         req_addr;
    logic [3:0]          req_len;
    logic [2:0]          req_size;
    logic [1:0]          req_burst;
    logic [3:0]          req_id;
    logic [BUSWIDTH-1:0] wr_data;
    logic [3:0]          wr_strb;
    logic                wr_data_valid;
    logic                wr_data_ready;
    logic                done;
    logic [1:0]          resp;

    logic [3:0]          AWID;
    logic [31:0]         AWADDR;
    logic [3:0]          AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic [1:0]          AWLOCK;
    logic [3:0]          AWCACHE;
    logic [2:0]          AWPROT;
    logic                AWVALID;
    logic                AWREADY;

    logic [3:0]          WID;
    logic [BUSWIDTH-1:0] WDATA;
    logic [3:0]          WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;

    logic [3:0]          BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        input  req_valid, req_addr, req_len, req_size, req_burst, req_id,
        input  wr_data, wr_strb, wr_data_valid,
        output req_ready, wr_data_ready, done, resp,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
        input  AWREADY,
        output WID, WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        output req_valid, req_addr, req_len, req_size, req_burst, req_id,
        output wr_data, wr_strb, wr_data_valid,
        input  req_ready, wr_data_ready, done, resp,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
        output AWREADY,
        input  WID, WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface
`default_nettype wire

// File: rtl/axi_write_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_write_master : AXI3 write master, one AW phase, counted W burst, B capture
// Optional B-channel timeout enabled by macro AXI_WR_TIMEOUT_EN.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module axi_write_master #(
    parameter int BUSWIDTH = 32,
    parameter int TIMEOUT  = 256
) (
    input  wire logic          ACLK,
    input  wire logic          ARESETn,
    axi_write_master_if.master bus
);

    localparam logic [2:0] c_max_size = 3'($clog2(BUSWIDTH / 8));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_beat_cnt;
    logic [3:0] w_load_idx;
    logic       w_w_hs;
    logic       w_data_ready;
    logic       w_accept;

`ifdef AXI_WR_TIMEOUT_EN
    localparam int c_tmo_w = $clog2(TIMEOUT + 1);
    logic [c_tmo_w-1:0] r_tmo_cnt;
`else
    // TIMEOUT has no effect when the timeout feature is compiled out.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    assign w_w_hs       = bus.WVALID && bus.WREADY;
    // Holding register refills on the cycle it drains; closed once the last beat sits in it.
    assign w_data_ready = (r_state == S_DATA) && (!bus.WVALID || (bus.WREADY && !bus.WLAST));
    assign w_accept     = bus.wr_data_valid && w_data_ready;
    assign w_load_idx   = w_w_hs ? (r_beat_cnt + 4'd1) : r_beat_cnt;

    assign bus.wr_data_ready = w_data_ready;
    assign bus.AWLOCK        = 2'b00;
    assign bus.AWCACHE       = 4'b0000;
    assign bus.AWPROT        = 3'b000;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state       <= S_IDLE;
            r_beat_cnt    <= 4'd0;
            bus.req_ready <= 1'b1;
            bus.done      <= 1'b0;
            bus.resp      <= 2'b00;
            bus.AWID      <= 4'd0;
            bus.AWADDR    <= 32'd0;
            bus.AWLEN     <= 4'd0;
            bus.AWSIZE    <= 3'd0;
            bus.AWBURST   <= 2'b00;
            bus.AWVALID   <= 1'b0;
            bus.WID       <= 4'd0;
            bus.WDATA     <= '0;
            bus.WSTRB     <= 4'd0;
            bus.WLAST     <= 1'b0;
            bus.WVALID    <= 1'b0;
            bus.BREADY    <= 1'b0;
`ifdef AXI_WR_TIMEOUT_EN
            r_tmo_cnt     <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        bus.AWID      <= bus.req_id;
                        bus.WID       <= bus.req_id;
                        bus.AWADDR    <= bus.req_addr;
                        bus.AWLEN     <= bus.req_len;
                        bus.AWSIZE    <= (bus.req_size > c_max_size) ? c_max_size : bus.req_size;
                        bus.AWBURST   <= (bus.req_burst == 2'b11) ? 2'b01 : bus.req_burst;
                        bus.AWVALID   <= 1'b1;
                        r_state       <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (bus.AWREADY) begin
                        bus.AWVALID <= 1'b0;
                        r_beat_cnt  <= 4'd0;
                        r_state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_w_hs) begin
                        r_beat_cnt <= r_beat_cnt + 4'd1;
                        if (bus.WLAST) begin
                            bus.WVALID <= 1'b0;
                            bus.WLAST  <= 1'b0;
                            bus.BREADY <= 1'b1;
                            r_state    <= S_RESP;
`ifdef AXI_WR_TIMEOUT_EN
                            r_tmo_cnt  <= '0;
`endif
                        end else if (!w_accept) begin
                            bus.WVALID <= 1'b0;
                        end
                    end
                    if (w_accept) begin
                        bus.WDATA  <= bus.wr_data;
                        bus.WSTRB  <= bus.wr_strb;
                        bus.WVALID <= 1'b1;
                        bus.WLAST  <= (w_load_idx == bus.AWLEN);
                    end
                end
                S_RESP: begin
                    if (bus.BVALID) begin
                        // An ID mismatch means the response is not ours: report SLVERR.
                        bus.resp      <= (bus.BID != bus.AWID) ? 2'b10 : bus.BRESP;
                        bus.done      <= 1'b1;
                        bus.BREADY    <= 1'b0;
                        bus.req_ready <= 1'b1;
                        r_state       <= S_IDLE;
                    end
`ifdef AXI_WR_TIMEOUT_EN
                    else if (r_tmo_cnt == c_tmo_w'(TIMEOUT - 1)) begin
                        bus.resp      <= 2'b11;
                        bus.done      <= 1'b1;
                        bus.BREADY    <= 1'b0;
                        bus.req_ready <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_write_master.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axi_write_master : directed self-checking bench for axi_write_master
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_axi_write_master;

    localparam int BUSWIDTH = 32;
    localparam int TIMEOUT  = 8;

    logic ACLK    = 1'b0;
    logic ARESETn = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic [1:0] last_resp = 2'b00;

    axi_write_master_if #(.BUSWIDTH(BUSWIDTH)) bus ();

    axi_write_master #(
        .BUSWIDTH (BUSWIDTH),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [31:0] pat(input logic [31:0] base, input int k);
        return base ^ (32'(k) * 32'h1111_1111);
    endfunction

    function automatic logic [3:0] strb(input int k);
        return 4'(15 - k);
    endfunction

    // Full transaction: request, AW with optional delay, W with per-beat 2-cycle stalls, B.
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [2:0] exp_size,
                           input logic [1:0] burst, input logic [1:0] exp_burst,
                           input logic [3:0] id, input int aw_delay, input logic [15:0] stall_mask,
                           input logic [1:0] bresp, input logic [3:0] bid,
                           input logic [1:0] exp_resp, input logic [31:0] base);
        int n, hs, k, stall;
        logic held, held_last;
        logic [31:0] held_data;
        n = 0;
        while (!bus.req_ready && n < 50) begin tick(); n++; end
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1; bus.req_addr = addr; bus.req_len = len;
        bus.req_size = size; bus.req_burst = burst; bus.req_id = id;
        tick();
        bus.req_valid = 1'b0;
        chk("awvalid_rise", 64'(bus.AWVALID), 64'd1);
        chk("awlen", 64'(bus.AWLEN), 64'(len));
        chk("awsize", 64'(bus.AWSIZE), 64'(exp_size));
        chk("awburst", 64'(bus.AWBURST), 64'(exp_burst));
        chk("awid", 64'(bus.AWID), 64'(id));
        chk("wid", 64'(bus.WID), 64'(id));
        chk("req_ready_busy", 64'(bus.req_ready), 64'd0);
        chk("done_low_start", 64'(bus.done), 64'd0);
        chk("resp_held", 64'(bus.resp), 64'(last_resp));
        chk("aw_fixed_zero", {bus.AWLOCK, bus.AWCACHE, bus.AWPROT}, 64'd0);
        for (int c = 0; c <= aw_delay; c++) begin
            bus.AWREADY = (c == aw_delay);
            chk("aw_hold_valid", 64'(bus.AWVALID), 64'd1);
            chk("aw_hold_addr", 64'(bus.AWADDR), 64'(addr));
            chk("no_w_before_aw", 64'(bus.WVALID), 64'd0);
            tick();
        end
        bus.AWREADY = 1'b0;
        chk("aw_drop", 64'(bus.AWVALID), 64'd0);
        hs = 0; k = 0; stall = 0; held = 1'b0; held_last = 1'b0; held_data = 32'd0; n = 0;
        while (!bus.BREADY && n < 200) begin
            if (held) begin
                chk("w_stall_data", 64'(bus.WDATA), 64'(held_data));
                chk("w_stall_last", 64'(bus.WLAST), 64'(held_last));
            end
            bus.WREADY        = !(bus.WVALID && hs < 16 && stall_mask[hs & 15] && stall < 2);
            bus.wr_data_valid = 1'b1;
            bus.wr_data       = pat(base, k);
            bus.wr_strb       = strb(k);
            #1;
            if (bus.wr_data_valid && bus.wr_data_ready) k++;
            held      = bus.WVALID && !bus.WREADY;
            held_data = bus.WDATA;
            held_last = bus.WLAST;
            if (held) stall++;
            if (bus.WVALID && bus.WREADY) begin
                chk("w_data", 64'(bus.WDATA), 64'(pat(base, hs)));
                chk("w_strb", 64'(bus.WSTRB), 64'(strb(hs)));
                chk("w_last", 64'(bus.WLAST), 64'(hs == int'(len)));
                hs++;
                stall = 0;
            end
            tick();
            n++;
        end
        bus.wr_data_valid = 1'b0;
        bus.WREADY        = 1'b0;
        chk("w_beats", 64'(hs), 64'(int'(len) + 1));
        chk("beats_taken", 64'(k), 64'(int'(len) + 1));
        chk("bready_up", 64'(bus.BREADY), 64'd1);
        chk("wvalid_off", 64'(bus.WVALID), 64'd0);
        tick();
        chk("wait_b_no_done", 64'(bus.done), 64'd0);
        bus.BVALID = 1'b1; bus.BRESP = bresp; bus.BID = bid;
        tick();
        bus.BVALID = 1'b0;
        chk("done_pulse", 64'(bus.done), 64'd1);
        chk("resp", 64'(bus.resp), 64'(exp_resp));
        chk("req_ready_at_done", 64'(bus.req_ready), 64'd1);
        chk("bready_drop", 64'(bus.BREADY), 64'd0);
        last_resp = exp_resp;
    endtask

    initial begin
        int n, hs;
        bus.req_valid = 1'b0; bus.req_addr = 32'd0; bus.req_len = 4'd0; bus.req_size = 3'd0;
        bus.req_burst = 2'b00; bus.req_id = 4'd0; bus.wr_data = 32'd0; bus.wr_strb = 4'd0;
        bus.wr_data_valid = 1'b0; bus.AWREADY = 1'b0; bus.WREADY = 1'b0;
        bus.BID = 4'd0; bus.BRESP = 2'b00; bus.BVALID = 1'b0;

        repeat (2) @(posedge ACLK);
        #1;
        chk("rst_awvalid", 64'(bus.AWVALID), 64'd0);
        chk("rst_wvalid", 64'(bus.WVALID), 64'd0);
        chk("rst_wlast", 64'(bus.WLAST), 64'd0);
        chk("rst_bready", 64'(bus.BREADY), 64'd0);
        chk("rst_done_resp", {bus.done, bus.resp}, 64'd0);
        chk("rst_aw_fields", {bus.AWID, bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST}, 64'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        tick();
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);

        // single beat, all readies high
        run_txn(32'h100, 4'd0, 3'd2, 3'd2, 2'b01, 2'b01, 4'd3, 0, 16'h0000,
                2'b00, 4'd3, 2'b00, 32'hDEAD_BEEF);
        // 4-beat INCR, beats 1 and 3 stalled two cycles each
        run_txn(32'h2000, 4'd3, 3'd2, 3'd2, 2'b01, 2'b01, 4'd5, 0, 16'h000A,
                2'b00, 4'd5, 2'b00, 32'hA5A5_0000);
        // AWREADY delayed three cycles, OKAY-with-EXOKAY response
        run_txn(32'h3004, 4'd1, 3'd1, 3'd1, 2'b10, 2'b10, 4'd7, 3, 16'h0000,
                2'b01, 4'd7, 2'b01, 32'h0BAD_F00D);
        // reserved burst and oversize transfer are sanitised
        run_txn(32'h4000, 4'd2, 3'd5, 3'd2, 2'b11, 2'b01, 4'd9, 0, 16'h0001,
                2'b00, 4'd9, 2'b00, 32'h1234_5678);
        // SLVERR response, then back-to-back request with BID mismatch
        run_txn(32'h5000, 4'd0, 3'd2, 3'd2, 2'b00, 2'b00, 4'd4, 0, 16'h0000,
                2'b10, 4'd4, 2'b10, 32'hCAFE_0001);
        run_txn(32'h6000, 4'd1, 3'd2, 3'd2, 2'b01, 2'b01, 4'd4, 0, 16'h0000,
                2'b00, 4'd6, 2'b10, 32'hCAFE_0002);
        tick();
        chk("done_one_cycle", 64'(bus.done), 64'd0);

`ifdef AXI_WR_TIMEOUT_EN
        bus.req_valid = 1'b1; bus.req_addr = 32'h7000; bus.req_len = 4'd0;
        bus.req_size = 3'd2; bus.req_burst = 2'b01; bus.req_id = 4'd2;
        tick();
        bus.req_valid = 1'b0; bus.AWREADY = 1'b1; bus.WREADY = 1'b1;
        bus.wr_data_valid = 1'b1; bus.wr_data = 32'h1357_9BDF; bus.wr_strb = 4'hF;
        n = 0;
        while (!bus.BREADY && n < 20) begin tick(); n++; end
        bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.wr_data_valid = 1'b0;
        chk("tmo_resp_entry", 64'(bus.BREADY), 64'd1);
        for (int c = 1; c <= TIMEOUT; c++) begin
            tick();
            if (c < TIMEOUT) chk("tmo_no_early_done", 64'(bus.done), 64'd0);
            else begin
                chk("tmo_done", 64'(bus.done), 64'd1);
                chk("tmo_resp", 64'(bus.resp), 64'd3);
                chk("tmo_bready_drop", 64'(bus.BREADY), 64'd0);
            end
        end
        bus.BVALID = 1'b1; bus.BID = 4'd2; bus.BRESP = 2'b00;
        tick();
        chk("late_b_ignored", 64'(bus.BREADY), 64'd0);
        chk("late_b_no_done", 64'(bus.done), 64'd0);
        bus.BVALID = 1'b0;
        tick();
`endif

        // reset after 2 of 4 beats
        bus.req_valid = 1'b1; bus.req_addr = 32'h8000; bus.req_len = 4'd3;
        bus.req_size = 3'd2; bus.req_burst = 2'b01; bus.req_id = 4'd1;
        tick();
        bus.req_valid = 1'b0; bus.AWREADY = 1'b1; bus.WREADY = 1'b1;
        bus.wr_data_valid = 1'b1; bus.wr_strb = 4'hF;
        hs = 0; n = 0;
        while (hs < 2 && n < 20) begin
            bus.wr_data = 32'h5555_0000 + 32'(n);
            if (bus.WVALID && bus.WREADY) hs++;
            tick();
            n++;
        end
        chk("rst_mid_two_beats", 64'(hs), 64'd2);
        chk("rst_mid_busy", 64'(bus.WVALID), 64'd1);
        #2;
        ARESETn = 1'b0;
        #1;
        chk("rst_mid_awvalid", 64'(bus.AWVALID), 64'd0);
        chk("rst_mid_w", {bus.WVALID, bus.WLAST, bus.WSTRB, bus.WDATA}, 64'd0);
        chk("rst_mid_bready", 64'(bus.BREADY), 64'd0);
        chk("rst_mid_done_resp", {bus.done, bus.resp}, 64'd0);
        chk("rst_mid_awaddr", 64'(bus.AWADDR), 64'd0);
        chk("rst_mid_wr_ready", 64'(bus.wr_data_ready), 64'd0);
        bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.wr_data_valid = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("rst_mid_no_done", 64'(bus.done), 64'd0);
        end
        chk("rst_mid_idle", 64'(bus.req_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
